axis_rx_port_arb: RTL and testbench

//  - Packet-granular round-robin arbiter. Merges two MAC-side AXI4-Stream RX ports

---
 rtl/axis_rx_port_arb.sv | 114 +++++++++++
 tb/tb_axis_rx_port_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rx_port_arb.sv
// Packet-granular round-robin arbiter merging two MAC RX AXI4-Stream ports onto one
// stream for the ibuf writer; stamps the source port ID and counts forwarded packets.
module axis_rx_port_arb #(
    parameter logic [7:0] SRC_PORT0 = 8'h01,
    parameter logic [7:0] SRC_PORT1 = 8'h02,
    parameter int         CNT_W     = 32
) (
    input  logic             s_axis_aclk,
    input  logic             s_axis_aresetn,

    input  logic [63:0]      s0_axis_tdata,
    input  logic [7:0]       s0_axis_tstrb,
    input  logic [127:0]     s0_axis_tuser,
    input  logic             s0_axis_tvalid,
    input  logic             s0_axis_tlast,
    output logic             s0_axis_tready,

    input  logic [63:0]      s1_axis_tdata,
    input  logic [7:0]       s1_axis_tstrb,
    input  logic [127:0]     s1_axis_tuser,
    input  logic             s1_axis_tvalid,
    input  logic             s1_axis_tlast,
    output logic             s1_axis_tready,

    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tstrb,
    output logic [127:0]     m_axis_tuser,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,

    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t state;
    logic   grant;
    logic   last_grant;

    logic   in_xfer;
    logic   sel_tvalid;
    logic   sel_tlast;
    logic   pkt_done;
    logic   unused_tuser_src;

    // The incoming source-ID byte is overwritten, so those input bits are intentionally dropped.
    assign unused_tuser_src = ^{s0_axis_tuser[31:24], s1_axis_tuser[31:24]};

    assign in_xfer = (state == XFER);

    always_comb begin
        sel_tvalid   = s0_axis_tvalid;
        sel_tlast    = s0_axis_tlast;
        m_axis_tdata = s0_axis_tdata;
        m_axis_tstrb = s0_axis_tstrb;
        m_axis_tuser = {s0_axis_tuser[127:32], SRC_PORT0, s0_axis_tuser[23:0]};
        if (grant) begin
            sel_tvalid   = s1_axis_tvalid;
            sel_tlast    = s1_axis_tlast;
            m_axis_tdata = s1_axis_tdata;
            m_axis_tstrb = s1_axis_tstrb;
            m_axis_tuser = {s1_axis_tuser[127:32], SRC_PORT1, s1_axis_tuser[23:0]};
        end
    end

    assign m_axis_tvalid  = in_xfer & sel_tvalid;
    assign m_axis_tlast   = sel_tlast;
    assign s0_axis_tready = in_xfer & ~grant & m_axis_tready;
    assign s1_axis_tready = in_xfer &  grant & m_axis_tready;
    assign pkt_done       = m_axis_tvalid & m_axis_tready & sel_tlast;

    // Grant is only re-evaluated in ARB, which keeps a packet's beats contiguous and stable.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state      <= ARB;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (s0_axis_tvalid && s1_axis_tvalid) begin
                        grant <= ~last_grant;
                        state <= XFER;
                    end else if (s0_axis_tvalid) begin
                        grant <= 1'b0;
                        state <= XFER;
                    end else if (s1_axis_tvalid) begin
                        grant <= 1'b1;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (pkt_done) begin
                        last_grant <= grant;
                        state      <= ARB;
                        if (grant) begin
                            pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
                        end else begin
                            pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rx_port_arb.sv
// Directed bench for axis_rx_port_arb: bench-side packet sources, an m-side beat log and
// hand-built expected beat sequences, checked with immediate assertions.
module tb_axis_rx_port_arb;

    localparam int CNT_W = 32;

    logic             s_axis_aclk = 1'b0;
    logic             s_axis_aresetn;
    logic [63:0]      s0_axis_tdata,  s1_axis_tdata,  m_axis_tdata;
    logic [7:0]       s0_axis_tstrb,  s1_axis_tstrb,  m_axis_tstrb;
    logic [127:0]     s0_axis_tuser,  s1_axis_tuser,  m_axis_tuser;
    logic             s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
    logic             s0_axis_tlast,  s1_axis_tlast,  m_axis_tlast;
    logic             s0_axis_tready, s1_axis_tready, m_axis_tready;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [63:0]  tdata;
        logic [7:0]   tstrb;
        logic [127:0] tuser;
        logic         tlast;
        int           cyc;
    } beat_t;

    beat_t mlog[$];
    beat_t exp_q[$];

    int pkts_left[2], pkt_idx[2], beat_no[2], plen[2];
    int stall_pkt[2], stall_beat[2], stall_left[2];
    bit hs[2];
    int owner = -1;
    int cyc = 0;
    bit rdy_random = 1'b0;
    bit watch_s0_idle = 1'b0;
    bit prev_stall = 1'b0;
    logic [63:0]  prev_tdata;
    logic [127:0] prev_tuser;
    logic         prev_tlast;

    axis_rx_port_arb #(.SRC_PORT0(8'h01), .SRC_PORT1(8'h02), .CNT_W(CNT_W)) dut (
        .s_axis_aclk    (s_axis_aclk),
        .s_axis_aresetn (s_axis_aresetn),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tstrb  (s0_axis_tstrb),
        .s0_axis_tuser  (s0_axis_tuser),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tstrb  (s1_axis_tstrb),
        .s1_axis_tuser  (s1_axis_tuser),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] mk_data(int p, int k, int b);
        return {8'(p), 8'hA5, 16'(k), 32'(b) + 32'h1000};
    endfunction

    function automatic logic [127:0] mk_user(int p, int k, int b, int l, logic [7:0] src);
        return {32'(p + 7), 32'(k), 32'hC0FFEE00 ^ 32'(b), src, 8'h5A, 16'(l * 8)};
    endfunction

    function automatic logic [7:0] mk_strb(int b, int l);
        return (b == l - 1) ? 8'h0F : 8'hFF;
    endfunction

    function automatic bit stalling(int p);
        return stall_left[p] > 0 && pkt_idx[p] == stall_pkt[p] && beat_no[p] == stall_beat[p];
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive_ports();
        s0_axis_tvalid = pkts_left[0] > 0 && !stalling(0);
        s0_axis_tdata  = mk_data(0, pkt_idx[0], beat_no[0]);
        s0_axis_tstrb  = mk_strb(beat_no[0], plen[0]);
        s0_axis_tuser  = mk_user(0, pkt_idx[0], beat_no[0], plen[0], 8'hEE);
        s0_axis_tlast  = beat_no[0] == plen[0] - 1;
        s1_axis_tvalid = pkts_left[1] > 0 && !stalling(1);
        s1_axis_tdata  = mk_data(1, pkt_idx[1], beat_no[1]);
        s1_axis_tstrb  = mk_strb(beat_no[1], plen[1]);
        s1_axis_tuser  = mk_user(1, pkt_idx[1], beat_no[1], plen[1], 8'hEE);
        s1_axis_tlast  = beat_no[1] == plen[1] - 1;
    endtask

    task automatic start_ports(input int n0, input int l0, input int n1, input int l1);
        pkts_left[0] = n0; plen[0] = l0;
        pkts_left[1] = n1; plen[1] = l1;
        for (int p = 0; p < 2; p++) begin
            pkt_idx[p] = 0; beat_no[p] = 0; stall_left[p] = 0;
            stall_pkt[p] = 0; stall_beat[p] = 0;
        end
        owner = -1;
        mlog.delete();
        exp_q.delete();
        drive_ports();
    endtask

    // One clock: invariant checks and logging on the falling edge, source advance after the rise.
    task automatic applyStimulus();
        @(negedge s_axis_aclk);
        checkOutput("both_tready", {127'b0, s0_axis_tready & s1_axis_tready}, '0);
        if (prev_stall) begin
            checkOutput("stall_tvalid", {127'b0, m_axis_tvalid}, 128'd1);
            checkOutput("stall_tdata", {64'b0, m_axis_tdata}, {64'b0, prev_tdata});
            checkOutput("stall_tuser", m_axis_tuser, prev_tuser);
            checkOutput("stall_tlast", {127'b0, m_axis_tlast}, {127'b0, prev_tlast});
        end
        if (owner >= 0)
            checkOutput("other_tready", {127'b0, (owner == 0) ? s1_axis_tready : s0_axis_tready}, '0);
        if (watch_s0_idle)
            checkOutput("s0_idle_tready", {127'b0, s0_axis_tready}, '0);
        hs[0] = s0_axis_tvalid && s0_axis_tready;
        hs[1] = s1_axis_tvalid && s1_axis_tready;
        if (m_axis_tvalid && m_axis_tready)
            mlog.push_back('{m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast, cyc});
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_tdata = m_axis_tdata;
        prev_tuser = m_axis_tuser;
        prev_tlast = m_axis_tlast;
        @(posedge s_axis_aclk);
        #1;
        cyc++;
        for (int p = 0; p < 2; p++) begin
            if (hs[p]) begin
                if (beat_no[p] == plen[p] - 1) begin
                    beat_no[p] = 0;
                    pkt_idx[p]++;
                    pkts_left[p]--;
                    owner = -1;
                end else begin
                    beat_no[p]++;
                    owner = p;
                end
            end else if (stalling(p)) begin
                stall_left[p]--;
            end
        end
        m_axis_tready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_ports();
    endtask

    task automatic run_traffic(input string tag, input int budget);
        int n = 0;
        while ((pkts_left[0] > 0 || pkts_left[1] > 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_done_in_budget"}, {127'b0, n < budget}, 128'd1);
        repeat (3) applyStimulus();
    endtask

    task automatic do_reset();
        s_axis_aresetn = 1'b0;
        #1;
        prev_stall = 1'b0;
        owner = -1;
        checkOutput("rst_s0_tready", {127'b0, s0_axis_tready}, '0);
        checkOutput("rst_s1_tready", {127'b0, s1_axis_tready}, '0);
        checkOutput("rst_m_tvalid", {127'b0, m_axis_tvalid}, '0);
        checkOutput("rst_cnt0", {96'b0, pkt_cnt0}, '0);
        checkOutput("rst_cnt1", {96'b0, pkt_cnt1}, '0);
        repeat (2) @(posedge s_axis_aclk);
        #1;
        s_axis_aresetn = 1'b1;
    endtask

    task automatic exp_pkt(input int p, input int k, input int l);
        for (int b = 0; b < l; b++)
            exp_q.push_back('{mk_data(p, k, b), mk_strb(b, l),
                              mk_user(p, k, b, l, (p == 1) ? 8'h02 : 8'h01), b == l - 1, 0});
    endtask

    task automatic compare_log(input string tag);
        checkOutput({tag, "_beat_count"}, 128'(mlog.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mlog.size(); i++) begin
            checkOutput({tag, "_tdata"}, {64'b0, mlog[i].tdata}, {64'b0, exp_q[i].tdata});
            checkOutput({tag, "_tstrb"}, {120'b0, mlog[i].tstrb}, {120'b0, exp_q[i].tstrb});
            checkOutput({tag, "_tuser"}, mlog[i].tuser, exp_q[i].tuser);
            checkOutput({tag, "_tlast"}, {127'b0, mlog[i].tlast}, {127'b0, exp_q[i].tlast});
        end
    endtask

    initial begin
        s_axis_aresetn = 1'b0;
        m_axis_tready  = 1'b1;
        start_ports(0, 1, 0, 1);

        $display("[TB] test 1: both valid at reset release");
        start_ports(1, 3, 1, 3);
        do_reset();
        run_traffic("t1", 40);
        exp_pkt(0, 0, 3);
        exp_pkt(1, 0, 3);
        compare_log("t1");
        if (mlog.size() >= 4)
            checkOutput("t1_idle_gap", 128'(mlog[3].cyc - mlog[2].cyc), 128'd2);
        checkOutput("t1_cnt0", {96'b0, pkt_cnt0}, 128'd1);
        checkOutput("t1_cnt1", {96'b0, pkt_cnt1}, 128'd1);

        $display("[TB] test 2: continuous alternation");
        start_ports(10, 2, 10, 2);
        do_reset();
        run_traffic("t2", 200);
        for (int k = 0; k < 10; k++) begin
            exp_pkt(0, k, 2);
            exp_pkt(1, k, 2);
        end
        compare_log("t2");
        checkOutput("t2_cnt0", {96'b0, pkt_cnt0}, 128'd10);
        checkOutput("t2_cnt1", {96'b0, pkt_cnt1}, 128'd10);

        $display("[TB] test 3: port 1 only, single-beat packets");
        start_ports(0, 1, 5, 1);
        do_reset();
        watch_s0_idle = 1'b1;
        run_traffic("t3", 60);
        watch_s0_idle = 1'b0;
        for (int k = 0; k < 5; k++) exp_pkt(1, k, 1);
        compare_log("t3");
        checkOutput("t3_cnt0", {96'b0, pkt_cnt0}, 128'd0);
        checkOutput("t3_cnt1", {96'b0, pkt_cnt1}, 128'd5);

        $display("[TB] test 4: random downstream stalls and source stall");
        start_ports(3, 4, 3, 4);
        stall_pkt[0] = 1; stall_beat[0] = 2; stall_left[0] = 4;
        do_reset();
        rdy_random = 1'b1;
        run_traffic("t4", 400);
        rdy_random = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_pkt(0, k, 4);
            exp_pkt(1, k, 4);
        end
        compare_log("t4");
        checkOutput("t4_cnt0", {96'b0, pkt_cnt0}, 128'd3);
        checkOutput("t4_cnt1", {96'b0, pkt_cnt1}, 128'd3);

        $display("[TB] test 5: reset in the middle of a packet");
        begin
            int n = 0;
            start_ports(1, 6, 1, 6);
            while (beat_no[0] != 2 && n < 50) begin
                applyStimulus();
                n++;
            end
            checkOutput("t5_reached_beat2", {127'b0, n < 50}, 128'd1);
            checkOutput("t5_pre_s0_tready", {127'b0, s0_axis_tready}, 128'd1);
            #2;
            s_axis_aresetn = 1'b0;
            #1;
            checkOutput("t5_s0_tready", {127'b0, s0_axis_tready}, '0);
            checkOutput("t5_s1_tready", {127'b0, s1_axis_tready}, '0);
            checkOutput("t5_m_tvalid", {127'b0, m_axis_tvalid}, '0);
            checkOutput("t5_cnt0", {96'b0, pkt_cnt0}, '0);
            checkOutput("t5_cnt1", {96'b0, pkt_cnt1}, '0);
            @(posedge s_axis_aclk);
            #1;
            start_ports(1, 2, 1, 2);
            do_reset();
            run_traffic("t5", 40);
            exp_pkt(0, 0, 2);
            exp_pkt(1, 0, 2);
            compare_log("t5");
        end

        $display("[TB] test 6: counter wrap");
        start_ports(0, 1, 1, 2);
        do_reset();
        run_traffic("t6a", 30);
        checkOutput("t6_cnt1_before", {96'b0, pkt_cnt1}, 128'd1);
        force dut.pkt_cnt0 = '1;
        #1;
        release dut.pkt_cnt0;
        #1;
        checkOutput("t6_cnt0_preload", {96'b0, pkt_cnt0}, {96'b0, 32'hFFFF_FFFF});
        start_ports(1, 3, 0, 1);
        run_traffic("t6b", 30);
        exp_pkt(0, 0, 3);
        compare_log("t6");
        checkOutput("t6_cnt0_wrap", {96'b0, pkt_cnt0}, 128'd0);
        checkOutput("t6_cnt1_kept", {96'b0, pkt_cnt1}, 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
